alloc_arbiter: RTL
==================

ALLOC_ARBITER -- requirements
Module: alloc_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of alloc requesters (2..8) SHALL be supported.
REQ-002 Parameter RETRY_GAP, 4, idle cycles between a blocked drop and its replay (1..15) SHALL be supported.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester alloc request valid.
REQ-006 req_id  input  NUM_REQ*`REQ_ID_WIDTH  per-requester request id, slice i for requester i.
REQ-007 req_size  input  NUM_REQ*`REQ_SIZE_TYPE_WIDTH  per-requester aligned size code (`REQ_512/`REQ_1K/`REQ_2K/`REQ_4K).
REQ-008 req_ready  output  NUM_REQ  one-hot grant; request i accepted when req_valid[i] & req_ready[i].
REQ-009 alloc_valid_dsp_out  output  1  alloc strobe to find_table.
REQ-010 alloc_id_dsp_out  output  `REQ_ID_WIDTH  id of issued request.
REQ-011 alloc_size_dsp_out  output  `REQ_SIZE_TYPE_WIDTH  size of issued request.
REQ-012 fdt_blocked  input  1  find_table blocked flag, reflects the alloc strobe of the previous cycle.
REQ-013 done_valid  output  1  one-cycle pulse: an issued request passed the blocked check.
REQ-014 done_src  output  3  requester index of the request reported by done_valid.
REQ-015 retry_cnt  output  8  saturating count of drops since reset.

Function
REQ-016 Exactly one request SHALL be in flight: issued at cycle T, judged at T+1 from fdt_blocked.
REQ-017 States SHALL be IDLE, CHECK, BACKOFF, REPLAY.
REQ-018 IDLE: if any req_valid, grant round-robin winner (search starts at last winner+1 mod NUM_REQ), drive alloc_valid_dsp_out=1 with its id/size same cycle, latch id/size/src into replay register, go CHECK; else stay, all outputs 0.
REQ-019 req_ready SHALL be asserted only in the cycle alloc_valid_dsp_out carries a new (non-replay) request, combinationally from req_valid and arbiter state.
REQ-020 CHECK with fdt_blocked=0: pulse done_valid with done_src=latched src; if any req_valid, issue next winner in the same cycle and stay CHECK (back-to-back, 1 req/cycle), else go IDLE.
REQ-021 CHECK with fdt_blocked=1: request dropped by find_table; no grant, no done_valid, retry_cnt+1 (saturate at 255), load gap counter with RETRY_GAP, go BACKOFF.
REQ-022 BACKOFF: alloc_valid_dsp_out=0, req_ready=0, decrement gap counter; at 1 go REPLAY.
REQ-023 REPLAY: drive alloc_valid_dsp_out=1 with replay register id/size, no grant, go CHECK; replay SHALL take priority over all new requests.
REQ-024 Round-robin pointer SHALL update only on a new grant, never on replay.
REQ-025 Requesters not granted SHALL hold req_valid/id/size stable; arbiter SHALL not require any requester to drop valid.
REQ-026 alloc_id_dsp_out/alloc_size_dsp_out SHALL be 0 whenever alloc_valid_dsp_out=0.
REQ-027 A replay blocked again SHALL repeat BACKOFF/REPLAY indefinitely with the same id/size; no starvation guard beyond retry_cnt.
REQ-028 fdt_blocked SHALL be ignored outside CHECK.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, req_ready=0, alloc_valid_dsp_out=0, id/size out=0, done_valid=0, done_src=0, retry_cnt=0, RR pointer so requester 0 wins first, replay register and gap counter 0.
REQ-030 A request in flight or in BACKOFF when reset asserts SHALL be discarded; no done_valid after release.
REQ-031 First grant SHALL be possible in the first clock edge after rst_n deasserts.

Verification
REQ-032 All 4 req_valid high, fdt_blocked=0 for 8 cycles -> grants 0,1,2,3,0,1,2,3 on consecutive cycles, done_valid each cycle from T+1 with matching done_src.
REQ-033 Req 2 id=5 size=`REQ_4K, fdt_blocked=1 at T+1 -> no done, retry_cnt=1, alloc_valid_dsp_out low T+1..T+4, replay id=5 size=`REQ_4K at T+5, done_valid src=2 at T+6 if unblocked.
REQ-034 Block persists 300 replays -> same id/size each replay, retry_cnt saturates at 255, req_ready stays 0 throughout.
REQ-035 Req 1 blocked while req 0/3 valid -> replay of req 1 issued before any new grant; next grant goes to 2-or-later per RR (3), pointer unchanged by replay.
REQ-036 rst_n pulsed low during BACKOFF -> all outputs 0 asynchronously, no replay after release, first grant to requester 0.

Source files
------------

// File: rtl/alloc_arbiter.sv
// Round-robin alloc arbiter with blocked-drop replay toward find_table.
// Latency: grant and issue in the same cycle, judged one cycle later; backpressure via fdt_blocked triggers backoff then replay.
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef REQ_SIZE_TYPE_WIDTH
`define REQ_SIZE_TYPE_WIDTH 2
`endif
`ifndef REQ_512
`define REQ_512 2'd0
`define REQ_1K  2'd1
`define REQ_2K  2'd2
`define REQ_4K  2'd3
`endif

module alloc_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int RETRY_GAP = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ*`REQ_ID_WIDTH-1:0]        req_id,
    input  logic [NUM_REQ*`REQ_SIZE_TYPE_WIDTH-1:0] req_size,
    output logic [NUM_REQ-1:0]                      req_ready,
    output logic                                    alloc_valid_dsp_out,
    output logic [`REQ_ID_WIDTH-1:0]                alloc_id_dsp_out,
    output logic [`REQ_SIZE_TYPE_WIDTH-1:0]         alloc_size_dsp_out,
    input  logic                                    fdt_blocked,
    output logic                                    done_valid,
    output logic [2:0]                              done_src,
    output logic [7:0]                              retry_cnt
);

    localparam int IW = `REQ_ID_WIDTH;
    localparam int SW = `REQ_SIZE_TYPE_WIDTH;

    typedef enum logic [1:0] {IDLE, CHECK, BACKOFF, REPLAY} state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [2:0]      src_q, src_d;
    logic [IW-1:0]   id_q, id_d;
    logic [SW-1:0]   size_q, size_d;
    logic [3:0]      gap_q, gap_d;
    logic [7:0]      retry_q, retry_d;

    logic            found_hi, found_lo;
    logic [2:0]      hi_idx, lo_idx, win_idx;
    logic [IW-1:0]   win_id;
    logic [SW-1:0]   win_size;
    logic            issue_new;

    // Prefer the first valid requester above the last winner, else wrap to the lowest valid one.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        win_id   = '0;
        win_size = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_hi && req_valid[i] && (3'(i) > ptr_q)) begin
                found_hi = 1'b1;
                hi_idx   = 3'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_lo && req_valid[i]) begin
                found_lo = 1'b1;
                lo_idx   = 3'(i);
            end
        end
        win_idx = found_hi ? hi_idx : lo_idx;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == 3'(i)) begin
                win_id   = req_id[i*IW +: IW];
                win_size = req_size[i*SW +: SW];
            end
        end
    end

    always_comb begin
        state_d             = state_q;
        ptr_d               = ptr_q;
        src_d               = src_q;
        id_d                = id_q;
        size_d              = size_q;
        gap_d               = gap_q;
        retry_d             = retry_q;
        issue_new           = 1'b0;
        req_ready           = '0;
        alloc_valid_dsp_out = 1'b0;
        alloc_id_dsp_out    = '0;
        alloc_size_dsp_out  = '0;
        done_valid          = 1'b0;
        done_src            = '0;

        case (state_q)
            IDLE: begin
                // Outputs are combinational, so hold off grants while reset is asserted.
                issue_new = found_lo && rst_n;
            end
            CHECK: begin
                if (fdt_blocked) begin
                    retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
                    if (RETRY_GAP <= 1) begin
                        state_d = REPLAY;
                    end else begin
                        gap_d   = 4'(RETRY_GAP);
                        state_d = BACKOFF;
                    end
                end else begin
                    done_valid = 1'b1;
                    done_src   = src_q;
                    if (found_lo) issue_new = 1'b1;
                    else          state_d   = IDLE;
                end
            end
            BACKOFF: begin
                gap_d = gap_q - 4'd1;
                if (gap_d == 4'd1) begin
                    gap_d   = '0;
                    state_d = REPLAY;
                end
            end
            REPLAY: begin
                alloc_valid_dsp_out = 1'b1;
                alloc_id_dsp_out    = id_q;
                alloc_size_dsp_out  = size_q;
                state_d             = CHECK;
            end
            default: state_d = IDLE;
        endcase

        if (issue_new) begin
            req_ready           = NUM_REQ'(1) << win_idx;
            alloc_valid_dsp_out = 1'b1;
            alloc_id_dsp_out    = win_id;
            alloc_size_dsp_out  = win_size;
            id_d                = win_id;
            size_d              = win_size;
            src_d               = win_idx;
            ptr_d               = win_idx;
            state_d             = CHECK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'(NUM_REQ - 1);
            src_q   <= '0;
            id_q    <= '0;
            size_q  <= '0;
            gap_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            id_q    <= id_d;
            size_q  <= size_d;
            gap_q   <= gap_d;
            retry_q <= retry_d;
        end
    end

    assign retry_cnt = retry_q;

endmodule
